f_pc_ctrl: RTL and testbench

F_PC_CTRL -- requirements
Module: f_pc_ctrl

---
 rtl/f_pc_ctrl.sv | 148 ++++++++++++++
 tb/tb_f_pc_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: fetches through imem into a registered F slot with a
// one-entry skid buffer, handling branch redirects, exception flushes and illegal fetch addresses.
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_LO     = 32'h0000_3000,
  parameter logic [31:0] PC_HI     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_valid,
  output logic        f_exc_adel
);

  typedef enum logic {S_REQ = 1'b0, S_FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_exc_q, skid_exc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic        f_valid_q, f_valid_d;
  logic        f_exc_q, f_exc_d;

  logic        pc_legal;
  logic        fetch_done;
  logic        accept;
  logic [31:0] done_instr;
  logic [31:0] pc_adv;

  always_comb begin
    pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q >= PC_LO) && (pc_q <= PC_HI);
    imem_req   = (state_q == S_REQ) && pc_legal;
    imem_addr  = pc_q;
    // An illegal address completes on its own without waiting for imem.
    fetch_done = (state_q == S_REQ) && (!pc_legal || imem_ready);
    done_instr = pc_legal ? imem_rdata : '0;
    accept     = f_valid_q && !stall;
    pc_adv     = pend_q ? pend_pc_q : pc_q + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_exc_d   = skid_exc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    f_pc_d       = f_pc_q;
    f_instr_d    = f_instr_q;
    f_valid_d    = f_valid_q;
    f_exc_d      = f_exc_q;

    if (req || eret) begin
      pc_d      = req ? EXC_ENTRY : epc;
      state_d   = S_REQ;
      f_valid_d = 1'b0;
      pend_d    = 1'b0;
    end else if (redirect_valid && f_valid_q) begin
      // Delay slot is leaving F: drop skid and any same-cycle completion.
      pc_d    = redirect_pc;
      state_d = S_REQ;
      pend_d  = 1'b0;
      if (accept) f_valid_d = 1'b0;
    end else begin
      if (redirect_valid) begin
        pend_d    = 1'b1;
        pend_pc_d = redirect_pc;
      end
      if (state_q == S_FULL) begin
        if (accept) begin
          f_pc_d    = skid_pc_q;
          f_instr_d = skid_instr_q;
          f_exc_d   = skid_exc_q;
          state_d   = S_REQ;
        end
      end else if (fetch_done) begin
        if (!f_valid_q || accept) begin
          f_pc_d    = pc_q;
          f_instr_d = done_instr;
          f_exc_d   = !pc_legal;
          f_valid_d = 1'b1;
        end else begin
          skid_pc_d    = pc_q;
          skid_instr_d = done_instr;
          skid_exc_d   = !pc_legal;
          state_d      = S_FULL;
        end
        // A completion coinciding with the redirect is itself the delay slot.
        pc_d   = redirect_valid ? redirect_pc : pc_adv;
        pend_d = 1'b0;
      end else if (accept) begin
        f_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_exc_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      f_pc_q       <= RESET_PC;
      f_instr_q    <= '0;
      f_valid_q    <= 1'b0;
      f_exc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_exc_q   <= skid_exc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      f_pc_q       <= f_pc_d;
      f_instr_q    <= f_instr_d;
      f_valid_q    <= f_valid_d;
      f_exc_q      <= f_exc_d;
    end
  end

  assign f_pc       = f_pc_q;
  assign f_instr    = f_instr_q;
  assign f_valid    = f_valid_q;
  assign f_exc_adel = f_exc_q;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed bench for f_pc_ctrl: sequential fetch, stall/skid, redirects, flushes,
// illegal addresses and reset during an in-flight fetch.
module tb_f_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        f_exc_adel;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ 32'hdead_0000;

  f_pc_ctrl #(
    .RESET_PC (32'h0000_3000),
    .EXC_ENTRY(32'h0000_4180),
    .PC_LO    (32'h0000_3000),
    .PC_HI    (32'h0000_6ffc)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .req           (req),
    .eret          (eret),
    .epc           (epc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .f_pc          (f_pc),
    .f_instr       (f_instr),
    .f_valid       (f_valid),
    .f_exc_adel    (f_exc_adel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0; epc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    step(); step();
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", f_valid); end
    total++; if (f_pc !== 32'h3000) begin bad++; $display("FAIL rst_fpc got=%h exp=00003000", f_pc); end
    total++; if (f_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", f_instr); end
    total++; if (f_exc_adel !== 1'b0) begin bad++; $display("FAIL rst_exc got=%0b exp=0", f_exc_adel); end
    reset = 1'b1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%0b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h3000) begin bad++; $display("FAIL rel_addr got=%h exp=00003000", imem_addr); end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h3000 + 32'(4 * i);
      step();
      total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, f_valid); end
      total++; if (f_pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, f_pc, exp_pc); end
      total++; if (f_instr !== (exp_pc ^ 32'hdead_0000)) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, f_instr, exp_pc ^ 32'hdead_0000); end
    end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL skid_req got=%0b exp=0", imem_req); end
    total++; if (f_pc !== 32'h3008) begin bad++; $display("FAIL skid_hold got=%h exp=00003008", f_pc); end
    step();
    total++; if (imem_req !== 1'b0 || f_pc !== 32'h3008) begin bad++; $display("FAIL skid_hold2 req=%0b pc=%h exp req=0 pc=00003008", imem_req, f_pc); end
    stall = 1'b0; imem_ready = 1'b0;
    step();
    total++; if (f_pc !== 32'h300c || f_valid !== 1'b1) begin bad++; $display("FAIL skid_out pc=%h v=%0b exp pc=0000300c v=1", f_pc, f_valid); end
    total++; if (f_instr !== (32'h300c ^ 32'hdead_0000)) begin bad++; $display("FAIL skid_instr got=%h exp=%h", f_instr, 32'h300c ^ 32'hdead_0000); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010) begin bad++; $display("FAIL skid_next req=%0b addr=%h exp req=1 addr=00003010", imem_req, imem_addr); end
    step();
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%0b exp=0", f_valid); end
  endtask

  task automatic test_redirect();
    // Slot empty: redirect becomes pending, delay slot 3010 still delivered.
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    total++; if (imem_addr !== 32'h3010) begin bad++; $display("FAIL pend_addr got=%h exp=00003010", imem_addr); end
    step();
    total++; if (f_pc !== 32'h3010 || f_valid !== 1'b1) begin bad++; $display("FAIL pend_dslot pc=%h v=%0b exp pc=00003010 v=1", f_pc, f_valid); end
    step();
    total++; if (f_pc !== 32'h3100) begin bad++; $display("FAIL pend_target got=%h exp=00003100", f_pc); end
    // Slot full and accepted: redirect takes effect at once.
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    step();
    redirect_valid = 1'b0;
    total++; if (f_valid !== 1'b0 || imem_addr !== 32'h3200) begin bad++; $display("FAIL redir v=%0b addr=%h exp v=0 addr=00003200", f_valid, imem_addr); end
    step();
    total++; if (f_pc !== 32'h3200 || f_valid !== 1'b1) begin bad++; $display("FAIL redir_out pc=%h v=%0b exp pc=00003200 v=1", f_pc, f_valid); end
  endtask

  task automatic test_flush();
    req = 1'b1; eret = 1'b1; epc = 32'h3020; redirect_valid = 1'b1; redirect_pc = 32'h3300;
    step();
    req = 1'b0; redirect_valid = 1'b0;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL exc_valid got=%0b exp=0", f_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180) begin bad++; $display("FAIL exc_addr req=%0b addr=%h exp req=1 addr=00004180", imem_req, imem_addr); end
    step();
    eret = 1'b0;
    total++; if (f_valid !== 1'b0 || imem_addr !== 32'h3020) begin bad++; $display("FAIL eret v=%0b addr=%h exp v=0 addr=00003020", f_valid, imem_addr); end
    step();
    total++; if (f_pc !== 32'h3020 || f_valid !== 1'b1) begin bad++; $display("FAIL eret_out pc=%h v=%0b exp pc=00003020 v=1", f_pc, f_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] tgt [2];
    tgt[0] = 32'h3102; tgt[1] = 32'h7000;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      redirect_valid = 1'b1; redirect_pc = tgt[i];
      step();
      redirect_valid = 1'b0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ill_req[%0d] got=%0b exp=0", i, imem_req); end
      step();
      total++; if (f_pc !== tgt[i] || f_valid !== 1'b1) begin bad++; $display("FAIL ill_pc[%0d] pc=%h v=%0b exp pc=%h v=1", i, f_pc, f_valid, tgt[i]); end
      total++; if (f_instr !== 32'h0 || f_exc_adel !== 1'b1) begin bad++; $display("FAIL ill_exc[%0d] instr=%h exc=%0b exp instr=0 exc=1", i, f_instr, f_exc_adel); end
    end
  endtask

  task automatic test_reset_midflight();
    req = 1'b1; imem_ready = 1'b1; stall = 1'b0;
    step();
    req = 1'b0;
    step();
    stall = 1'b1;
    step();
    total++; if (imem_req !== 1'b0 || f_pc !== 32'h4180) begin bad++; $display("FAIL pre_full req=%0b pc=%h exp req=0 pc=00004180", imem_req, f_pc); end
    reset = 1'b0;
    step();
    total++; if (f_valid !== 1'b0 || f_pc !== 32'h3000 || f_instr !== 32'h0 || f_exc_adel !== 1'b0) begin
      bad++; $display("FAIL rst2_slot v=%0b pc=%h instr=%h exc=%0b exp v=0 pc=00003000 instr=0 exc=0", f_valid, f_pc, f_instr, f_exc_adel);
    end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin bad++; $display("FAIL rst2_fetch req=%0b addr=%h exp req=1 addr=00003000", imem_req, imem_addr); end
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    step(); step();
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL rst2_noskid got=%0b exp=0", f_valid); end
    imem_ready = 1'b1;
    step();
    total++; if (f_pc !== 32'h3000 || f_valid !== 1'b1) begin bad++; $display("FAIL rst2_first pc=%h v=%0b exp pc=00003000 v=1", f_pc, f_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect();
    test_flush();
    test_illegal();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
